// File: rtl/fir_par_cfg.sv
// fir_par_cfg: P-parallel block FIR with a double-buffered coefficient bank,
// a three-stage pipeline (products, adder tree, round/saturate), a sticky
// saturation flag and a synchronous flush.
//
// Handshake: a beat is accepted on every rising edge where in_valid=1 and
// flush=0; there is no ready/backpressure. out_valid is the accepted-beat
// marker delayed by three register stages. y_out is updated only together
// with out_valid=1 and otherwise holds its last value.
module fir_par_cfg #(
  parameter int P     = 6,
  parameter int N     = 24,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int OW    = 16,
  parameter int SHIFT = 15,
  localparam int AD   = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [P*DW-1:0]   x_in,
  input  logic              flush,
  input  logic              coef_we,
  input  logic [AD-1:0]     coef_addr,
  input  logic [CW-1:0]     coef_wdata,
  input  logic              coef_commit,
  output logic              out_valid,
  output logic [P*OW-1:0]   y_out,
  output logic              sat_flag,
  output logic              busy
);

  localparam int PW   = DW + CW;
  localparam int ACCW = PW + $clog2(N);
  localparam int HL   = (N > 1) ? N - 1 : 1;
  localparam int EL   = N - 1 + P;
  localparam int SH1  = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [ACCW:0] RND  = (SHIFT > 0) ? ((ACCW+1)'(1) <<< SH1) : '0;
  localparam logic signed [ACCW:0] MAXV = {{(ACCW+2-OW){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACCW:0] MINV = {{(ACCW+2-OW){1'b1}}, {(OW-1){1'b0}}};

  // Sample history: index 0 is the oldest of the last N-1 samples.
  logic signed [DW-1:0]   hist_q   [HL];
  logic signed [DW-1:0]   hist_d   [HL];
  logic signed [CW-1:0]   shadow_q [N];
  logic signed [CW-1:0]   shadow_d [N];
  logic signed [CW-1:0]   active_q [N];
  logic signed [CW-1:0]   active_d [N];
  logic signed [DW-1:0]   ext      [EL];
  logic signed [PW-1:0]   prod_q   [P][N];
  logic signed [PW-1:0]   prod_d   [P][N];
  logic signed [ACCW-1:0] acc_q    [P];
  logic signed [ACCW-1:0] acc_d    [P];
  logic signed [ACCW:0]   rnd;
  logic signed [ACCW:0]   shv;
  logic [P*OW-1:0]        y_sat;
  logic [P-1:0]           clip;
  logic [P*OW-1:0]        y_q, y_d;
  logic                   sat_q, sat_d;
  logic                   v1_q, v2_q, v3_q;
  logic                   v1_d, v2_d, v3_d;

  // Time-ordered window: history followed by the P new lanes (lane 0 oldest).
  always_comb begin
    for (int m = 0; m < N - 1; m++) ext[m] = hist_q[m];
    for (int i = 0; i < P; i++) ext[N-1+i] = $signed(x_in[i*DW +: DW]);
  end

  // History shifts by P on an accepted beat; flush restarts it at zero.
  always_comb begin
    hist_d = hist_q;
    if (flush) begin
      for (int m = 0; m < HL; m++) hist_d[m] = '0;
    end else if (in_valid) begin
      for (int m = 0; m < N - 1; m++) hist_d[m] = ext[m+P];
    end
  end

  // Shadow write lands first so a same-cycle commit carries it; flush blocks commit.
  always_comb begin
    shadow_d = shadow_q;
    for (int j = 0; j < N; j++) begin
      if (coef_we && (coef_addr == AD'(j))) shadow_d[j] = coef_wdata;
    end
    active_d = active_q;
    if (coef_commit && !flush) active_d = shadow_d;
  end

  // S1 products: lane i output sample pairs tap j with window entry N-1+i-j.
  always_comb begin
    for (int i = 0; i < P; i++) begin
      for (int j = 0; j < N; j++) begin
        prod_d[i][j] = PW'(ext[N-1+i-j]) * PW'(active_q[j]);
      end
    end
  end

  // S2 full-precision sum of each lane's products.
  always_comb begin
    for (int i = 0; i < P; i++) begin
      acc_d[i] = '0;
      for (int j = 0; j < N; j++) acc_d[i] = acc_d[i] + ACCW'(prod_q[i][j]);
    end
  end

  // S3 round half up, arithmetic shift, clamp to the signed output range.
  always_comb begin
    y_sat = '0;
    clip  = '0;
    rnd   = '0;
    shv   = '0;
    for (int i = 0; i < P; i++) begin
      rnd = (ACCW+1)'(acc_q[i]) + RND;
      shv = rnd >>> SHIFT;
      if (shv > MAXV) begin
        y_sat[i*OW +: OW] = MAXV[OW-1:0];
        clip[i] = 1'b1;
      end else if (shv < MINV) begin
        y_sat[i*OW +: OW] = MINV[OW-1:0];
        clip[i] = 1'b1;
      end else begin
        y_sat[i*OW +: OW] = shv[OW-1:0];
      end
    end
  end

  // Valid chain and output-stage next state; flush kills in-flight beats.
  always_comb begin
    v1_d  = in_valid & ~flush;
    v2_d  = v1_q & ~flush;
    v3_d  = v2_q & ~flush;
    y_d   = y_q;
    sat_d = sat_q;
    if (flush) begin
      sat_d = 1'b0;
    end else if (v2_q) begin
      y_d   = y_sat;
      sat_d = sat_q | (|clip);
    end
  end

  // History and coefficient bank registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < HL; m++) hist_q[m] <= '0;
      for (int j = 0; j < N; j++) begin
        shadow_q[j] <= '0;
        active_q[j] <= '0;
      end
    end else begin
      hist_q   <= hist_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // Pipeline data registers (S1 products, S2 sums).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < P; i++) begin
        acc_q[i] <= '0;
        for (int j = 0; j < N; j++) prod_q[i][j] <= '0;
      end
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

  // Valid bits, output register and sticky saturation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      y_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      y_q   <= y_d;
      sat_q <= sat_d;
    end
  end

  assign out_valid = v3_q;
  assign y_out     = y_q;
  assign sat_flag  = sat_q;
  assign busy      = v1_q | v2_q | v3_q;

endmodule

// File: tb/tb_fir_par_cfg.sv
// Bench for fir_par_cfg: directed scenarios plus a random phase, checked
// every cycle against a convolution model over the full sample history.
module tb_fir_par_cfg;

  localparam int P = 6, N = 24, DW = 16, CW = 16, OW = 16, SHIFT = 15;
  localparam int AD = $clog2(N);
  localparam int MAXC = 2048;
  localparam longint OMAX = (longint'(1) << (OW-1)) - 1;
  localparam longint OMIN = -(longint'(1) << (OW-1));

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic [P*DW-1:0] x_in = '0;
  logic            flush = 1'b0;
  logic            coef_we = 1'b0;
  logic [AD-1:0]   coef_addr = '0;
  logic [CW-1:0]   coef_wdata = '0;
  logic            coef_commit = 1'b0;
  logic            out_valid;
  logic [P*OW-1:0] y_out;
  logic            sat_flag;
  logic            busy;

  fir_par_cfg #(.P(P), .N(N), .DW(DW), .CW(CW), .OW(OW), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x_in(x_in), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_commit(coef_commit), .out_valid(out_valid), .y_out(y_out),
    .sat_flag(sat_flag), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: every sample since reset/flush, and both banks.
  longint hist[$];
  longint sh [N];
  longint act[N];
  // Per-cycle record of accepted beats and their expected results.
  bit  bv  [MAXC];
  bit  bfl [MAXC];
  bit  bsat[MAXC];
  int  by  [MAXC][P];
  int  ey  [P];
  bit  esat;
  int  s = 2;
  int  xl  [P];

  task automatic chk(string tag, longint obs, longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, s);
    end
  endtask

  function automatic int round_sat(longint acc, output bit clipped);
    longint r;
    r = (SHIFT > 0) ? ((acc + (longint'(1) << (SHIFT-1))) >>> SHIFT) : acc;
    clipped = 1'b0;
    if (r > OMAX) begin r = OMAX; clipped = 1'b1; end
    if (r < OMIN) begin r = OMIN; clipped = 1'b1; end
    return int'(r);
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int j = 0; j < N; j++) begin sh[j] = 0; act[j] = 0; end
    for (int c = 0; c < MAXC; c++) begin bv[c] = 0; bfl[c] = 0; bsat[c] = 0; end
    for (int i = 0; i < P; i++) ey[i] = 0;
    esat = 0;
  endtask

  task automatic set_x(int v);
    for (int i = 0; i < P; i++) xl[i] = v;
  endtask

  // Driver + model for one clock cycle, then check outputs after the edge.
  task automatic cyc(bit iv, bit fl, bit we, int addr, int wd, bit cm);
    bit v, b, c;
    longint acc;
    int base, n;
    in_valid    = iv;
    flush       = fl;
    coef_we     = we;
    coef_addr   = addr[AD-1:0];
    coef_wdata  = wd[CW-1:0];
    coef_commit = cm;
    for (int i = 0; i < P; i++) x_in[i*DW +: DW] = xl[i][DW-1:0];

    bfl[s]  = fl;
    bv[s]   = iv && !fl;
    bsat[s] = 0;
    if (bv[s]) begin
      for (int i = 0; i < P; i++) hist.push_back(longint'(xl[i]));
      base = hist.size() - P;
      for (int i = 0; i < P; i++) begin
        n = base + i;
        acc = 0;
        for (int j = 0; j < N; j++) if (n - j >= 0) acc += act[j] * hist[n-j];
        by[s][i] = round_sat(acc, c);
        if (c) bsat[s] = 1;
      end
    end
    if (fl) hist.delete();
    if (we && addr < N) sh[addr] = wd;
    if (cm && !fl) act = sh;

    @(posedge clk);
    #1;
    // Result of the beat accepted two edges ago, unless a flush intervened.
    v = bv[s-2] && !bfl[s-1] && !bfl[s];
    b = bv[s] || (bv[s-1] && !bfl[s]) || v;
    if (bfl[s]) esat = 0;
    else if (v) begin
      ey = by[s-2];
      esat = esat | bsat[s-2];
    end
    chk("out_valid", out_valid, v);
    chk("busy", busy, b);
    chk("sat_flag", sat_flag, esat);
    for (int i = 0; i < P; i++)
      chk($sformatf("y_lane%0d", i), $signed(y_out[i*OW +: OW]), ey[i]);
    s++;
  endtask

  task automatic idle(int k);
    set_x(0);
    for (int t = 0; t < k; t++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  // mode 0: constant val; mode 1: ramp val*(j+1). Commit rides on the last write.
  task automatic load_bank(int mode, int val);
    set_x(0);
    for (int j = 0; j < N; j++)
      cyc(0, 0, 1, j, (mode == 0) ? val : val * (j + 1), j == N - 1);
  endtask

  task automatic impulse_run(int amp);
    set_x(0); xl[0] = amp;
    cyc(1, 0, 0, 0, 0, 0);
    set_x(0);
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 0, 0);
    idle(3);
  endtask

  initial begin
    // Reset state
    model_reset();
    set_x(0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_y", y_out, 0);
    rst_n = 1'b1;

    // Impulse with a ramp bank: beat k lane i = (6k+i+1)*512
    load_bank(1, 1024);
    impulse_run(16384);

    // Out-of-range addresses and uncommitted shadow writes leave the filter unchanged
    set_x(0);
    for (int a = N; a < (1 << AD); a++) cyc(0, 0, 1, a, 12345, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 999, 0);
    impulse_run(16384);

    // Q15 step response: ramps up by 512 per sample, settles at 12288
    load_bank(0, 1024);
    set_x(16384);
    for (int k = 0; k < 8; k++) cyc(1, 0, 0, 0, 0, 0);
    idle(3);

    // Saturation at both rails, then flush clears the sticky flag
    load_bank(0, 32767);
    set_x(32767);
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0, 0, 0);
    set_x(-32768);
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0, 0, 0);
    idle(3);
    cyc(0, 1, 0, 0, 0, 0);
    idle(2);

    // Bubbles: valid pattern 1,0,0,1,1
    load_bank(1, 1024);
    set_x(0); xl[0] = 16384;
    cyc(1, 0, 0, 0, 0, 0);
    set_x(0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(4);

    // Coefficient swap mid-stream: commit with beat 1, beats 2-3 see -(j+1)*1024
    cyc(0, 1, 0, 0, 0, 0);
    for (int j = 0; j < N - 2; j++) cyc(0, 0, 1, j, -1024 * (j + 1), 0);
    set_x(0); xl[0] = 16384;
    cyc(1, 0, 1, N - 2, -1024 * (N - 1), 0);
    set_x(0);
    cyc(1, 0, 1, N - 1, -1024 * N, 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(4);

    // Flush during an impulse tail, with in_valid and commit in the flush cycle
    load_bank(1, 1024);
    set_x(0);
    for (int j = 0; j < N; j++) cyc(0, 0, 1, j, 7, 0);
    xl[0] = 16384;
    cyc(1, 0, 0, 0, 0, 0);
    set_x(0);
    cyc(1, 0, 0, 0, 0, 0);
    set_x(20000);
    cyc(1, 1, 0, 0, 0, 1);
    set_x(0);
    cyc(1, 0, 0, 0, 0, 0);
    impulse_run(16384);

    // Randomised traffic with occasional coefficient traffic and flushes
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < P; i++) xl[i] = int'($urandom_range(0, 65535)) - 32768;
      cyc(($urandom_range(0, 3) != 0),
          ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 2) == 0),
          int'($urandom_range(0, (1 << AD) - 1)),
          int'($urandom_range(0, 65535)) - 32768,
          ($urandom_range(0, 15) == 0));
    end
    idle(3);

    // Asynchronous reset mid-stream
    set_x(3000);
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_sat", sat_flag, 0);
    chk("arst_y", y_out, 0);
    model_reset();
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    load_bank(1, 1024);
    impulse_run(16384);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
